// File: rtl/hoene_frame_controller_pkg.sv
// Shared types and defaults for the smart-LED frame controller.
// Holds the FSM state enum, default geometry and the frame length.
package hoene_frame_controller_pkg;

    localparam int DEF_CHANNELS = 3;
    localparam int DEF_BITS     = 8;
    localparam int FRAME_BITS   = DEF_CHANNELS * DEF_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FORWARD,
        ST_ERROR
    } state_t;

    // Counter width able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hoene_shift_capture.sv
// Shadow shift register plus saturating bit counter for one frame.
// Ports: clear, shift_en, bit_in in; shadow, done (this shift fills it) out.
module hoene_shift_capture
    import hoene_frame_controller_pkg::*;
#(
    parameter int W = FRAME_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [W-1:0] shadow,
    output logic         done
);

    localparam int CW = cnt_width(W);

    logic [CW-1:0] count;

    // done is combinational so the FSM can leave CAPTURE on the
    // very strobe that completes the frame.
    assign done = shift_en && (count == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            count  <= '0;
        end else if (clear) begin
            shadow <= '0;
            count  <= '0;
        end else if (shift_en) begin
            shadow <= {shadow[W-2:0], bit_in};
            if (count != CW'(W))
                count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hoene_frame_controller.sv
// Frame sequencer: captures this node's channel bits, forwards the rest.
// Ports: decoded bit stream in; ch_value/update, fwd_*, frame_err, busy out.
module hoene_frame_controller
    import hoene_frame_controller_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int BITS     = DEF_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_data,
    input  logic                     in_clk,
    input  logic                     in_error,
    input  logic                     insync,
    output logic [CHANNELS*BITS-1:0] ch_value,
    output logic                     update,
    output logic                     fwd_data,
    output logic                     fwd_clk,
    output logic                     fwd_en,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int FB = CHANNELS * BITS;

    state_t        state;
    logic          insync_q;
    logic          rise;
    logic          strobe;
    logic          cap_clear;
    logic          cap_shift;
    logic          cap_done;
    logic [FB-1:0] shadow;

    assign rise   = insync & ~insync_q;
    assign strobe = in_clk & insync;

    assign cap_clear = (state == ST_IDLE) && rise;
    assign cap_shift = (state == ST_CAPTURE) && strobe && !in_error;

    assign fwd_en = (state == ST_FORWARD);
    assign busy   = (state != ST_IDLE);

    hoene_shift_capture #(
        .W (FB)
    ) u_cap (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cap_clear),
        .shift_en (cap_shift),
        .bit_in   (in_data),
        .shadow   (shadow),
        .done     (cap_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            insync_q  <= 1'b0;
            ch_value  <= '0;
            update    <= 1'b0;
            fwd_data  <= 1'b0;
            fwd_clk   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            insync_q <= insync;
            update   <= 1'b0;
            fwd_clk  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state     <= ST_CAPTURE;
                        frame_err <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (in_error) begin
                        state     <= ST_ERROR;
                        frame_err <= 1'b1;
                    end else if (!insync) begin
                        state     <= ST_IDLE;
                        frame_err <= 1'b1;
                    end else if (cap_done) begin
                        state <= ST_FORWARD;
                    end
                end
                ST_FORWARD: begin
                    if (in_error) begin
                        state     <= ST_ERROR;
                        frame_err <= 1'b1;
                    end else if (!insync) begin
                        state    <= ST_IDLE;
                        ch_value <= shadow;
                        update   <= 1'b1;
                    end else if (strobe) begin
                        fwd_clk  <= 1'b1;
                        fwd_data <= in_data;
                    end
                end
                ST_ERROR: begin
                    if (!insync)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hoene_frame_controller.sv
// Self-checking bench for hoene_frame_controller.
// Scoreboard queues hold expected forwarded bits and commits.
module tb_hoene_frame_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_data = 1'b0;
    logic        in_clk = 1'b0;
    logic        in_error = 1'b0;
    logic        insync = 1'b0;
    logic [23:0] ch_value;
    logic        update;
    logic        fwd_data;
    logic        fwd_clk;
    logic        fwd_en;
    logic        frame_err;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;
    int n_upd = 0;
    int n_fwd = 0;
    int exp_upd = 0;
    int exp_fwd = 0;

    logic        fwd_q[$];
    logic [23:0] commit_q[$];

    // model state: 0 idle, 1 capture, 2 forward, 3 error
    int          mst = 0;
    int          mcnt = 0;
    logic [23:0] mshadow = '0;
    logic [23:0] exp_ch = '0;

    hoene_frame_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_clk    (in_clk),
        .in_error  (in_error),
        .insync    (insync),
        .ch_value  (ch_value),
        .update    (update),
        .fwd_data  (fwd_data),
        .fwd_clk   (fwd_clk),
        .fwd_en    (fwd_en),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (fwd_clk) begin
                n_fwd++;
                if (fwd_q.size() == 0)
                    chk("fwd_unexp", 32'(fwd_clk), 0);
                else
                    chk("fwd_bit", 32'(fwd_data), 32'(fwd_q.pop_front()));
            end
            if (update) begin
                n_upd++;
                if (commit_q.size() == 0)
                    chk("upd_unexp", 32'(update), 0);
                else
                    chk("commit", 32'(ch_value), 32'(commit_q.pop_front()));
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ch"}, 32'(ch_value), 0);
        chk({tag, "_upd"}, 32'(update), 0);
        chk({tag, "_fd"}, 32'(fwd_data), 0);
        chk({tag, "_fc"}, 32'(fwd_clk), 0);
        chk({tag, "_fen"}, 32'(fwd_en), 0);
        chk({tag, "_ferr"}, 32'(frame_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic start_frame(input logic strobe);
        mst = 1;
        mcnt = 0;
        mshadow = '0;
        insync = 1'b1;
        in_clk = strobe;
        in_data = 1'b1;
        @(posedge clk);
        #1;
        chk("start_busy", 32'(busy), 1);
        chk("start_ferr", 32'(frame_err), 0);
        chk("start_upd", 32'(update), 0);
        @(negedge clk);
        in_clk = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic e);
        logic err_hit;
        err_hit = 1'b0;
        if (mst == 1 || mst == 2) begin
            if (e) begin
                mst = 3;
                err_hit = 1'b1;
            end else if (mst == 1) begin
                mshadow = {mshadow[22:0], b};
                mcnt++;
                if (mcnt == 24)
                    mst = 2;
            end else begin
                fwd_q.push_back(b);
                exp_fwd++;
            end
        end
        in_clk = 1'b1;
        in_data = b;
        in_error = e;
        @(posedge clk);
        #1;
        if (err_hit) begin
            chk("err_fen", 32'(fwd_en), 0);
            chk("err_ferr", 32'(frame_err), 1);
            chk("err_busy", 32'(busy), 1);
        end
        @(negedge clk);
        in_clk = 1'b0;
        in_error = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            send_bit(v[i], 1'b0);
    endtask

    task automatic end_frame();
        logic exp_u;
        logic exp_e;
        exp_u = (mst == 2);
        exp_e = (mst != 2);
        if (exp_u) begin
            commit_q.push_back(mshadow);
            exp_upd++;
            exp_ch = mshadow;
        end
        mst = 0;
        insync = 1'b0;
        @(posedge clk);
        #1;
        chk("end_upd", 32'(update), 32'(exp_u));
        chk("end_fen", 32'(fwd_en), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_ferr", 32'(frame_err), 32'(exp_e));
        chk("end_ch", 32'(ch_value), 32'(exp_ch));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        insync = 1'b0;
        in_clk = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        idle(2);

        // Frame: 12 34 56 captured, A5 forwarded
        start_frame(1'b0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        chk("fwd_en_on", 32'(fwd_en), 1);
        send_byte(8'hA5);
        end_frame();
        idle(2);

        // Short frame of 10 bits
        start_frame(1'b0);
        for (int i = 0; i < 10; i++)
            send_bit(1'(i), 1'b0);
        end_frame();
        idle(2);

        // 40-bit frame with error on bit 30
        start_frame(1'b0);
        for (int i = 1; i <= 40; i++)
            send_bit(1'($urandom_range(1)), i == 30);
        end_frame();
        idle(2);

        // Strobe coincident with insync rise is ignored
        start_frame(1'b1);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        end_frame();
        idle(2);

        // Async reset after 12 captured bits
        start_frame(1'b0);
        send_byte(8'h9C);
        for (int i = 0; i < 4; i++)
            send_bit(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        insync = 1'b0;
        #1;
        chk_zero("arst");
        mst = 0;
        exp_ch = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        start_frame(1'b0);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'hFF);
        end_frame();
        idle(2);

        // Back-to-back frames, one low cycle apart
        start_frame(1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_bit(1'b1, 1'b0);
        end_frame();
        start_frame(1'b0);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        end_frame();
        idle(4);

        chk("final_ch", 32'(ch_value), 32'h445566);
        chk("fwd_left", 32'(fwd_q.size()), 0);
        chk("cmt_left", 32'(commit_q.size()), 0);
        chk("upd_count", 32'(n_upd), 32'(exp_upd));
        chk("fwd_count", 32'(n_fwd), 32'(exp_fwd));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
